// File: rtl/insn_fetch_unit.sv
// RV32I instruction fetch stage: issues word fetches over req/ack, holds the
// fetched instruction for the decoders, and steers the next PC on retirement.
module insn_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] insn,
  output logic [31:0] pc,
  output logic        insn_valid,
  input  logic        insn_ready,
  input  logic        pc_next_sel,
  input  logic [31:0] pc_target,
  output logic        fetch_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned CW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   insn_q;
  logic [31:0]   pc_q;
  logic [31:0]   pc_next;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pc_next    = pc_next_sel ? pc_target : pc_q + 32'd4;
    unique case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (mem_ack)            state_next = HOLD;
        else if (count == LAST) state_next = ERR;
      end
      HOLD: begin
        if (insn_ready) state_next = (pc_next[1:0] != 2'b00) ? ERR : REQ;
      end
      ERR:     state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  // fetch_pc doubles as mem_addr, so the address only moves on entry to REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      insn_q   <= NOP;
      pc_q     <= RESET_PC;
      count    <= '0;
    end else begin
      unique case (state)
        REQ: begin
          if (mem_ack) begin
            insn_q <= mem_rdata;
            pc_q   <= fetch_pc;
            count  <= '0;
          end else if (count != LAST) begin
            count <= count + CW'(1);
          end
        end
        HOLD: begin
          if (insn_ready && pc_next[1:0] == 2'b00) fetch_pc <= pc_next;
        end
        default: ;
      endcase
    end
  end

  assign mem_req    = (state == REQ);
  assign mem_addr   = fetch_pc;
  assign insn       = insn_q;
  assign pc         = pc_q;
  assign insn_valid = (state == HOLD);
  assign fetch_err  = (state == ERR);

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Scoreboard bench for insn_fetch_unit: two instances (reset PC 0 and
// 0xFFFFFFFC); expected fetch addresses and instructions are queued by the stimulus.
module tb_insn_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // instance 0: RESET_PC = 0
  logic        r0 = 1'b1, ack0 = 1'b0, ready0 = 1'b0, sel0 = 1'b0;
  logic [31:0] rdata0 = '0, tgt0 = '0;
  logic        mem_req0, insn_valid0, fetch_err0;
  logic [31:0] mem_addr0, insn0, pc0;

  // instance 1: RESET_PC = 0xFFFFFFFC
  logic        r1 = 1'b1, ack1 = 1'b0, ready1 = 1'b0, sel1 = 1'b0;
  logic [31:0] rdata1 = '0, tgt1 = '0;
  logic        mem_req1, insn_valid1, fetch_err1;
  logic [31:0] mem_addr1, insn1, pc1;

  insn_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) u0 (
    .clk(clk), .reset(r0), .mem_req(mem_req0), .mem_addr(mem_addr0),
    .mem_rdata(rdata0), .mem_ack(ack0), .insn(insn0), .pc(pc0),
    .insn_valid(insn_valid0), .insn_ready(ready0), .pc_next_sel(sel0),
    .pc_target(tgt0), .fetch_err(fetch_err0)
  );

  insn_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(16)) u1 (
    .clk(clk), .reset(r1), .mem_req(mem_req1), .mem_addr(mem_addr1),
    .mem_rdata(rdata1), .mem_ack(ack1), .insn(insn1), .pc(pc1),
    .insn_valid(insn_valid1), .insn_ready(ready1), .pc_next_sel(sel1),
    .pc_target(tgt1), .fetch_err(fetch_err1)
  );

  logic [31:0] exp_addr0[$];
  logic [31:0] exp_addr1[$];
  logic [63:0] exp_insn0[$];
  logic [63:0] exp_insn1[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each new request and each newly valid instruction pops an expectation.
  logic prev_req0 = 1'b0, prev_val0 = 1'b0, prev_req1 = 1'b0, prev_val1 = 1'b0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (mem_req0 === 1'b1 && !prev_req0) begin
      if (exp_addr0.size() == 0) begin
        checks++; failures++;
        $display("FAIL u0_req unexpected request actual=%h expected=none", mem_addr0);
      end else check32("u0_req_addr", mem_addr0, exp_addr0.pop_front());
    end
    if (insn_valid0 === 1'b1 && !prev_val0) begin
      if (exp_insn0.size() == 0) begin
        checks++; failures++;
        $display("FAIL u0_insn unexpected insn actual=%h expected=none", insn0);
      end else begin
        e = exp_insn0.pop_front();
        check32("u0_insn", insn0, e[63:32]);
        check32("u0_pc", pc0, e[31:0]);
      end
    end
    if (mem_req1 === 1'b1 && !prev_req1) begin
      if (exp_addr1.size() == 0) begin
        checks++; failures++;
        $display("FAIL u1_req unexpected request actual=%h expected=none", mem_addr1);
      end else check32("u1_req_addr", mem_addr1, exp_addr1.pop_front());
    end
    if (insn_valid1 === 1'b1 && !prev_val1) begin
      if (exp_insn1.size() == 0) begin
        checks++; failures++;
        $display("FAIL u1_insn unexpected insn actual=%h expected=none", insn1);
      end else begin
        e = exp_insn1.pop_front();
        check32("u1_insn", insn1, e[63:32]);
        check32("u1_pc", pc1, e[31:0]);
      end
    end
    prev_req0 = (mem_req0 === 1'b1);
    prev_val0 = (insn_valid0 === 1'b1);
    prev_req1 = (mem_req1 === 1'b1);
    prev_val1 = (insn_valid1 === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    // ---- reset state, instance 0
    step(); step();
    check32("rst_mem_req", 32'(mem_req0), 32'd0);
    check32("rst_mem_addr", mem_addr0, 32'h0);
    check32("rst_insn", insn0, 32'h0000_0013);
    check32("rst_pc", pc0, 32'h0);
    check32("rst_valid", 32'(insn_valid0), 32'd0);
    check32("rst_err", 32'(fetch_err0), 32'd0);
    r0 = 1'b0;
    exp_addr0.push_back(32'h0);
    step(); // IDLE cycle consumed, now REQ
    check32("first_req", 32'(mem_req0), 32'd1);
    ack0 = 1'b1; rdata0 = 32'h1234_5117;
    exp_insn0.push_back({32'h1234_5117, 32'h0});
    step(); // HOLD
    ack0 = 1'b0;
    check32("first_valid", 32'(insn_valid0), 32'd1);

    // ---- stall 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check32("stall_insn", insn0, 32'h1234_5117);
      check32("stall_pc", pc0, 32'h0);
      check32("stall_req", 32'(mem_req0), 32'd0);
    end

    // ---- sequential retire
    ready0 = 1'b1; sel0 = 1'b0; tgt0 = 32'hDEAD_BEEF;
    exp_addr0.push_back(32'h4);
    step();
    ready0 = 1'b0;
    check32("seq_req", 32'(mem_req0), 32'd1);
    check32("seq_addr", mem_addr0, 32'h4);
    check32("seq_valid", 32'(insn_valid0), 32'd0);
    ack0 = 1'b1; rdata0 = 32'h0040_0093;
    exp_insn0.push_back({32'h0040_0093, 32'h4});
    step();
    ack0 = 1'b0;

    // ---- jump
    ready0 = 1'b1; sel0 = 1'b1; tgt0 = 32'h0000_0100;
    exp_addr0.push_back(32'h100);
    step();
    ready0 = 1'b0; sel0 = 1'b0;
    ack0 = 1'b1; rdata0 = 32'h0000_006F;
    exp_insn0.push_back({32'h0000_006F, 32'h100});
    step();
    ack0 = 1'b0;
    check32("jump_pc", pc0, 32'h100);

    // ---- misaligned target; later ack/ready must be ignored
    ready0 = 1'b1; sel0 = 1'b1; tgt0 = 32'h0000_0102;
    step();
    check32("mis_err", 32'(fetch_err0), 32'd1);
    check32("mis_req", 32'(mem_req0), 32'd0);
    check32("mis_valid", 32'(insn_valid0), 32'd0);
    ack0 = 1'b1; sel0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check32("err_sticky", {30'd0, fetch_err0, mem_req0}, 32'd2);
    end
    ack0 = 1'b0; ready0 = 1'b0;
    r0 = 1'b1;
    step();
    r0 = 1'b0;
    check32("err_clear", 32'(fetch_err0), 32'd0);

    // ---- timeout
    exp_addr0.push_back(32'h0);
    step(); // now REQ
    n = 0;
    while (mem_req0 === 1'b1 && n < 40) begin
      n++;
      step();
    end
    check32("timeout_req_cycles", n, 32'd16);
    check32("timeout_err", 32'(fetch_err0), 32'd1);
    ack0 = 1'b1; rdata0 = 32'hAAAA_AAAA;
    step();
    ack0 = 1'b0;
    check32("late_ack_err", 32'(fetch_err0), 32'd1);
    check32("late_ack_valid", 32'(insn_valid0), 32'd0);
    check32("late_ack_insn", insn0, 32'h0000_0013);

    // ---- instance 1: wrap and reset-during-REQ
    check32("u1_rst_pc", pc1, 32'hFFFF_FFFC);
    check32("u1_rst_addr", mem_addr1, 32'hFFFF_FFFC);
    r1 = 1'b0;
    exp_addr1.push_back(32'hFFFF_FFFC);
    step(); // REQ
    ack1 = 1'b1; rdata1 = 32'hABCD_0037;
    exp_insn1.push_back({32'hABCD_0037, 32'hFFFF_FFFC});
    step(); // HOLD
    ack1 = 1'b0;
    ready1 = 1'b1; sel1 = 1'b0;
    exp_addr1.push_back(32'h0);
    step(); // REQ at wrapped address
    ready1 = 1'b0;
    check32("wrap_addr", mem_addr1, 32'h0);
    check32("wrap_err", 32'(fetch_err1), 32'd0);
    r1 = 1'b1; ack1 = 1'b1; rdata1 = 32'hDEAD_BEEF;
    step();
    check32("rreq_valid", 32'(insn_valid1), 32'd0);
    check32("rreq_pc", pc1, 32'hFFFF_FFFC);
    check32("rreq_insn", insn1, 32'h0000_0013);
    check32("rreq_addr", mem_addr1, 32'hFFFF_FFFC);
    r1 = 1'b0;
    exp_addr1.push_back(32'hFFFF_FFFC);
    step(); // ack during IDLE dropped, now REQ
    check32("idle_ack_req", 32'(mem_req1), 32'd1);
    check32("idle_ack_insn", insn1, 32'h0000_0013);
    ack1 = 1'b0;
    step(); step();

    check32("sb_drained", exp_addr0.size() + exp_insn0.size()
                          + exp_addr1.size() + exp_insn1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/insn_fetch_unit.md
Name: insn_fetch_unit

Overview:
- Instruction fetch stage of the RV32I core. It sits directly upstream of the instruction-type decoders (R/I/S/B/U/J) in the control unit.
- It holds the current PC and issues a word fetch to instruction memory through a req/ack handshake.
- It latches the returned word into the `insn` register and presents it, with its PC, to the decoders under a valid/ready handshake.
- On retirement it selects the next PC: either PC+4 or the ALU-computed target, steered by the `pc_next_sel` produced by the decoders.

Parameters:
- RESET_PC, 32'h00000000: PC loaded on reset.
- TIMEOUT_CYCLES, 16: consecutive REQ cycles without `mem_ack` before a fetch error is raised.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  fetch request to instruction memory.
- mem_addr  out  32  word address of the fetch.
- mem_rdata  in  32  fetched instruction word; sampled only when `mem_req` and `mem_ack` are both 1.
- mem_ack  in  1  memory accepts the request and returns `mem_rdata` in the same cycle.
- insn  out  32  latched instruction, fed to the decoders.
- pc  out  32  address of `insn`, fed to the PC/ALU path (auipc, jal, branches).
- insn_valid  out  1  `insn` and `pc` are valid and stable.
- insn_ready  in  1  control unit retires the current instruction.
- pc_next_sel  in  1  from the decoders: 0 = `pc`+4, 1 = `pc_target`.
- pc_target  in  32  jump/branch target from the ALU.
- fetch_err  out  1  sticky error flag (misaligned target or timeout).

Behaviour:
- Reset (`reset`=1 at a clock edge), forces:
  - state=IDLE, `mem_req`=0, `mem_addr`=RESET_PC, fetch_pc=RESET_PC;
  - `insn`=32'h00000013 (NOP), `pc`=RESET_PC, `insn_valid`=0, `fetch_err`=0, timeout counter=0.
  - Reset overrides every other input in the same cycle.
- States:
  - IDLE: outputs hold reset values. Next cycle goes to REQ unconditionally. `mem_ack` is ignored.
  - REQ: `mem_req`=1, `mem_addr`=fetch_pc, `insn_valid`=0.
    - `mem_ack`=1: `insn`<=`mem_rdata`, `pc`<=fetch_pc, counter<=0, go to HOLD.
    - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 with no ack, go to ERR.
  - HOLD: `mem_req`=0, `insn_valid`=1, `insn` and `pc` stable.
    - `insn_ready`=1: next = `pc_next_sel` ? `pc_target` : `pc`+4.
    - If next[1:0] != 2'b00, go to ERR.
    - Else fetch_pc<=next, `mem_addr`<=next, go to REQ.
    - `insn_ready`=0: remain in HOLD indefinitely with no change.
  - ERR: `mem_req`=0, `insn_valid`=0, `fetch_err`=1. Leaves only on reset.
- Latency:
  - Ack accepted at edge N gives `insn_valid`=1 from cycle N+1.
  - Ready accepted at edge M gives `mem_req`=1 with the new address from cycle M+1.
  - Best-case throughput is one instruction per 2 cycles.
- Arithmetic: `pc`+4 is 32-bit modulo 2^32; 32'hFFFFFFFC+4 = 32'h00000000 with no error.
- `pc_target`/`pc_next_sel` are sampled only in HOLD with `insn_ready`=1. They are don't-care at all other times.
- `mem_ack` outside REQ is ignored and has no side effect.
- `insn_ready` outside HOLD is ignored.
- Reset mid-REQ or mid-HOLD abandons the fetch. An ack arriving in the reset cycle or the following IDLE cycle is dropped.
- `mem_addr` changes only on entry to REQ or on reset, so it stays stable for the whole request.

Test Plan:
- Reset release (RESET_PC=0): cycle 1 IDLE with `mem_req`=0; cycle 2 `mem_req`=1, `mem_addr`=0. Ack with `mem_rdata`=32'h12345117 -> next cycle `insn`=32'h12345117, `pc`=0, `insn_valid`=1.
- Stall and sequential retire:
  - Hold `insn_ready`=0 for 5 cycles -> `insn`/`pc` unchanged, `mem_req`=0.
  - Then `insn_ready`=1, `pc_next_sel`=0 -> next cycle `mem_req`=1, `mem_addr`=32'h4, `insn_valid`=0.
- Jump: in HOLD, `pc_next_sel`=1, `pc_target`=32'h00000100, `insn_ready`=1 -> `mem_addr`=32'h100. After ack, `pc`=32'h100.
- Misaligned target: `pc_target`=32'h00000102 with `pc_next_sel`=1 and `insn_ready`=1 -> `fetch_err`=1, `mem_req`=0, `insn_valid`=0. State persists 20 cycles and clears only after reset.
- Timeout: withhold `mem_ack` -> `mem_req` stays 1 for exactly 16 cycles, then `fetch_err`=1. A late ack is ignored.
- Wrap and reset:
  - RESET_PC=32'hFFFFFFFC; fetch, retire with `pc_next_sel`=0 -> `mem_addr`=0, `fetch_err`=0.
  - Assert `reset` during the next REQ while driving `mem_ack`=1 -> `insn_valid`=0, `pc`=32'hFFFFFFFC, the ack is dropped.
